uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter FRAME_BITS, default 8: number of data bits per frame, sent LSB first.
REQ-002 Parameter STOP_BITS, default 1: number of stop-bit periods (1 or 2).
REQ-003 Port CLK50MHZ, input, 1: system clock, single clock domain; all logic SHALL be clocked on its rising edge.
REQ-004 Port RST_N, input, 1: reset, asynchronous, active-low.
REQ-005 Ports req0, req1, input, 1 each: requester wants to send one frame; level, held until ack.
REQ-006 Ports data0, data1, input, FRAME_BITS each: payload; stable while the matching req is high.
REQ-007 Ports ack0, ack1, output, 1 each: one-cycle pulse; the payload is captured.
REQ-008 Port tick, input, 1: baud tick from the team's baud rate generator; single-cycle pulse.
REQ-009 Port baud_en, output, 1: enable to the baud rate generator.
REQ-010 Port baud_clr, output, 1: synchronous clear to the generator accumulator.
REQ-011 Port txd, output, 1: serial line, idle high.
REQ-012 Port busy, output, 1: high while a frame is in progress.
REQ-013 Port grant, output, 1: index of the requester owning the current or last frame.

Function
REQ-014 States SHALL be IDLE, START, DATA, STOP.
REQ-015 IDLE: txd=1; baud_en=0; busy=0; tick ignored.
REQ-016 Arbitration SHALL happen in IDLE only and SHALL be round-robin.
REQ-017 With one req high, that requester SHALL win.
REQ-018 With both high, the requester not granted last SHALL win; after reset req0 SHALL win.
REQ-019 On win, in the same cycle: ack of the winner=1 for exactly one cycle; baud_clr=1 for exactly one cycle; payload latched into the shift register; grant updated; next state START.
REQ-020 START: txd=0; baud_en=1; busy=1; on tick go to DATA with bit counter=0.
REQ-021 DATA: txd=shift_reg[0]; on each tick shift right and increment the counter; on the tick at counter=FRAME_BITS-1 go to STOP.
REQ-022 STOP: txd=1; stay STOP_BITS tick periods, then go to IDLE; baud_en=0 from the IDLE cycle onward.
REQ-023 txd SHALL be registered (glitch-free); each bit SHALL last exactly one tick interval, the start bit measured from the cycle after baud_clr.
REQ-024 A new grant SHALL occur no earlier than the first IDLE cycle after the final stop tick, giving back-to-back frames with no idle bit.
REQ-025 A req dropped before ack SHALL be ignored without error; a req raised during a frame SHALL wait.
REQ-026 A tick coinciding with a grant cycle SHALL be ignored; START waits for the next tick.
REQ-027 data inputs SHALL be sampled only in the ack cycle; later changes SHALL NOT affect the frame.

Reset
REQ-028 On RST_N low, immediately: state=IDLE, txd=1, baud_en=0, baud_clr=0, busy=0, ack0=ack1=0, grant=1 (so req0 wins first), shift register and counters 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with txd=1 at once; no ack SHALL be reissued for it.
REQ-030 After release, the first grant SHALL be possible on the first clock edge.

Verification
REQ-031 req0=1, data0=8'hA5, tick every 4 cycles -> ack0 pulse; txd=0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each 4 cycles; busy low after stop.
REQ-032 req0=req1=1 from reset, data0=8'h01, data1=8'h80 -> frame 8'h01 then 8'h80 back-to-back; grant 0 then 1; each ack once.
REQ-033 req1 held continuously, req0 raised mid-frame -> next grant goes to req0 (round-robin), then req1.
REQ-034 RST_N low during DATA bit 3 -> txd=1 and busy=0 asynchronously; after release an idle line and no stale ack.
REQ-035 tick forced high in the grant cycle -> START still lasts one full tick interval; baud_clr pulse seen exactly once per frame.
REQ-036 STOP_BITS=2, data0=8'hFF -> stop level lasts 2 tick intervals before the next start bit.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - two-requester round-robin UART frame transmitter
module uart_tx_arbiter #(
    parameter int FRAME_BITS = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  CLK50MHZ,
    input  logic                  RST_N,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [FRAME_BITS-1:0] data0,
    input  logic [FRAME_BITS-1:0] data1,
    output logic                  ack0,
    output logic                  ack1,
    input  logic                  tick,
    output logic                  baud_en,
    output logic                  baud_clr,
    output logic                  txd,
    output logic                  busy,
    output logic                  grant
);

    localparam int BIT_CW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_n;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [FRAME_BITS-1:0] shift_n;
    logic [BIT_CW-1:0]     bit_cnt;
    logic [BIT_CW-1:0]     bit_n;
    logic [1:0]            stop_cnt;
    logic [1:0]            stop_n;
    logic                  grant_n;
    logic                  txd_n;
    logic                  take;
    logic                  win_sel;

    // Round-robin choice: on contention the requester not granted last wins.
    always_comb begin
        win_sel = 1'b0;
        take    = 1'b0;
        if (state == IDLE && (req0 || req1)) begin
            take    = 1'b1;
            win_sel = (req0 && req1) ? ~grant : req1;
        end
    end

    // Grant-cycle strobes are combinational so the payload is captured in the
    // same cycle as ack; RST_N masks them because IDLE is also the reset state.
    assign ack0     = RST_N & take & ~win_sel;
    assign ack1     = RST_N & take & win_sel;
    assign baud_clr = RST_N & take;

    // The generator only runs while a frame is on the line.
    assign busy    = (state != IDLE);
    assign baud_en = (state != IDLE);

    // State register.
    always_ff @(posedge CLK50MHZ or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, shifter and counter update; txd_n is derived from the next
    // state so the registered line changes exactly on the transition edge.
    always_comb begin
        state_n = state;
        shift_n = shift_reg;
        bit_n   = bit_cnt;
        stop_n  = stop_cnt;
        grant_n = grant;
        case (state)
            IDLE: begin
                if (take) begin
                    state_n = START;
                    shift_n = win_sel ? data1 : data0;
                    grant_n = win_sel;
                    bit_n   = '0;
                    stop_n  = '0;
                end
            end
            START: begin
                if (tick) begin
                    state_n = DATA;
                    bit_n   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_n = shift_reg >> 1;
                    if (bit_cnt == BIT_CW'(FRAME_BITS - 1)) begin
                        state_n = STOP;
                        stop_n  = '0;
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_cnt == 2'(STOP_BITS - 1)) begin
                        state_n = IDLE;
                    end else begin
                        stop_n = stop_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shift_n[0];
            default: txd_n = 1'b1;
        endcase
    end

    // Datapath registers; reset forces the line idle immediately.
    always_ff @(posedge CLK50MHZ or negedge RST_N) begin
        if (!RST_N) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= '0;
            grant     <= 1'b1;
            txd       <= 1'b1;
        end else begin
            shift_reg <= shift_n;
            bit_cnt   <= bit_n;
            stop_cnt  <= stop_n;
            grant     <= grant_n;
            txd       <= txd_n;
        end
    end

endmodule
